eth_tx_arb: RTL and testbench

// - Frame-level round-robin arbiter sharing the single eth_tx byte-stream port among N_REQ sources.
// - Locks one requester from its SOF beat until frame end and muxes its beats to eth_tx.
// - Routes tx_ack back to the granted source, discards stray beats and keeps saturating statistics.
// - Sits between packet builders (ARP/UDP/etc.) and eth_tx in the clk_mac domain.

---
 rtl/eth_tx_arb_pkg.sv | 22 ++
 rtl/eth_tx_arb_rr_pick.sv | 30 +++
 rtl/eth_tx_arb.sv | 170 +++++++++++++++++
 tb/tb_eth_tx_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the frame-level eth_tx arbiter.
// Holds the arbiter state encoding, the counter width default and a popcount helper.
package eth_tx_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    localparam int DEF_CNT_W = 16;
    localparam int MAX_REQ   = 8;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/eth_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, with wrap.
module eth_rr_pick
    import eth_tx_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic             any,
    output logic [2:0]       idx
);

    logic [MAX_REQ-1:0] req_s;
    logic [2:0]         cand_s;

    assign req_s = MAX_REQ'(req);

    // Scan furthest candidate first so the nearest one after ptr wins last.
    always_comb begin
        any    = 1'b0;
        idx    = 3'd0;
        cand_s = 3'd0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_s = 3'((int'(ptr) + k) % N_REQ);
            any    = any | req_s[cand_s];
            idx    = req_s[cand_s] ? cand_s : idx;
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter sharing the eth_tx byte stream among N_REQ sources.
// One source is locked from its SOF beat to frame end; stray idle beats are flushed and counted.
module eth_tx_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic               clk_mac,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_en,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [8*N_REQ-1:0] req_dat,
    input  logic [N_REQ-1:0]   req_sof,
    input  logic [N_REQ-1:0]   req_eof,
    input  logic [N_REQ-1:0]   req_err,
    output logic [N_REQ-1:0]   req_ack,
    output logic               tx_vld,
    output logic [7:0]         tx_dat,
    output logic               tx_sof,
    output logic               tx_eof,
    output logic               tx_err,
    input  logic               tx_ack,
    output logic               grant_vld,
    output logic [2:0]         grant_idx,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   abort_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int SUM_W = CNT_W + 1;

    arb_state_e         state_r;
    arb_state_e         state_nxt_s;
    logic [2:0]         grant_idx_r;
    logic [2:0]         rr_ptr_r;
    logic [CNT_W-1:0]   frame_cnt_r;
    logic [CNT_W-1:0]   abort_cnt_r;
    logic [CNT_W-1:0]   drop_cnt_r;
    logic [MAX_REQ-1:0] vld8_s;
    logic [MAX_REQ-1:0] sof8_s;
    logic [MAX_REQ-1:0] eof8_s;
    logic [MAX_REQ-1:0] err8_s;
    logic [MAX_REQ-1:0] ack8_s;
    logic [MAX_REQ-1:0] stray8_s;
    logic [7:0]         dat8_s [MAX_REQ];
    logic [N_REQ-1:0]   cand_s;
    logic               pick_any_s;
    logic [2:0]         pick_idx_s;
    logic               release_s;
    logic               frame_end_s;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [3:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + SUM_W'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Widen per-source vectors to the 8-source maximum so a 3-bit grant index never overruns.
    assign vld8_s = MAX_REQ'(req_vld);
    assign sof8_s = MAX_REQ'(req_sof);
    assign eof8_s = MAX_REQ'(req_eof);
    assign err8_s = MAX_REQ'(req_err);

    for (genvar i = 0; i < MAX_REQ; i++) begin : g_dat
        if (i < N_REQ) begin : g_real
            assign dat8_s[i] = req_dat[8*i +: 8];
        end else begin : g_pad
            assign dat8_s[i] = 8'h00;
        end
    end

    assign cand_s = req_vld & req_sof & req_en;

    eth_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (cand_s),
        .ptr (rr_ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    assign release_s   = (state_r == ARB_LOCK) && tx_ack && (!tx_vld || tx_err || tx_eof);
    assign frame_end_s = release_s && tx_vld && tx_eof && !tx_err;

    // State register.
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: lock on a pick, return to idle on release.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) state_nxt_s = ARB_LOCK;
                else            state_nxt_s = ARB_IDLE;
            end
            ARB_LOCK: begin
                if (release_s) state_nxt_s = ARB_IDLE;
                else           state_nxt_s = ARB_LOCK;
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Output mux and ack return; reset forces every strobe low immediately.
    always_comb begin
        tx_vld   = 1'b0;
        tx_dat   = 8'h00;
        tx_sof   = 1'b0;
        tx_eof   = 1'b0;
        tx_err   = 1'b0;
        ack8_s   = {MAX_REQ{1'b0}};
        stray8_s = {MAX_REQ{1'b0}};
        if (rst) begin
            ack8_s = {MAX_REQ{1'b0}};
        end else if (state_r == ARB_LOCK) begin
            tx_vld              = vld8_s[grant_idx_r];
            tx_dat              = dat8_s[grant_idx_r];
            tx_sof              = sof8_s[grant_idx_r];
            tx_eof              = eof8_s[grant_idx_r];
            tx_err              = err8_s[grant_idx_r];
            ack8_s[grant_idx_r] = tx_ack;
        end else begin
            stray8_s = MAX_REQ'(req_vld & ~req_sof & req_en);
            ack8_s   = stray8_s;
        end
    end

    // Grant index and round-robin pointer update at arbitration.
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            grant_idx_r <= 3'd0;
            rr_ptr_r    <= 3'(N_REQ - 1);
        end else if (state_r == ARB_IDLE && pick_any_s) begin
            grant_idx_r <= pick_idx_s;
            rr_ptr_r    <= pick_idx_s;
        end
    end

    // Saturating statistics; a frame with both eof and err counts as an abort.
    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            abort_cnt_r <= {CNT_W{1'b0}};
            drop_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (frame_end_s) begin
                frame_cnt_r <= sat_add(frame_cnt_r, 4'd1);
            end
            if (release_s && !frame_end_s) begin
                abort_cnt_r <= sat_add(abort_cnt_r, 4'd1);
            end
            drop_cnt_r <= sat_add(drop_cnt_r, popcount8(stray8_s));
        end
    end

    assign req_ack   = ack8_s[N_REQ-1:0];
    assign grant_vld = (state_r == ARB_LOCK);
    assign grant_idx = grant_idx_r;
    assign frame_cnt = frame_cnt_r;
    assign abort_cnt = abort_cnt_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: two frame sources, an always-ready eth_tx sink, scenario tasks.
module tb_eth_tx_arb;

    localparam int N   = 2;
    localparam int CW  = 4;

    logic          clk_mac = 1'b0;
    logic          rst     = 1'b1;
    logic [N-1:0]  req_en  = '0;
    logic [N-1:0]  req_vld = '0;
    logic [8*N-1:0] req_dat = '0;
    logic [N-1:0]  req_sof = '0;
    logic [N-1:0]  req_eof = '0;
    logic [N-1:0]  req_err = '0;
    logic [N-1:0]  req_ack;
    logic          tx_vld;
    logic [7:0]    tx_dat;
    logic          tx_sof;
    logic          tx_eof;
    logic          tx_err;
    logic          tx_ack  = 1'b0;
    logic          grant_vld;
    logic [2:0]    grant_idx;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] abort_cnt;
    logic [CW-1:0] drop_cnt;

    int passed = 0;
    int total  = 0;

    // Source model state: frame length (data beats incl. SOF), frames left, fault points.
    int s_len[N], s_nfr[N], s_drop[N], s_err[N], s_pos[N], s_start[N];
    // Observations gathered by run().
    int gseq[$];
    int nbeats[N];
    int order_err, b2b, txv_cnt, gv_after_err, first_tx_cyc;

    eth_tx_arb #(.N_REQ(N), .CNT_W(CW)) dut (
        .clk_mac(clk_mac), .rst(rst), .req_en(req_en), .req_vld(req_vld),
        .req_dat(req_dat), .req_sof(req_sof), .req_eof(req_eof), .req_err(req_err),
        .req_ack(req_ack), .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_sof(tx_sof),
        .tx_eof(tx_eof), .tx_err(tx_err), .tx_ack(tx_ack), .grant_vld(grant_vld),
        .grant_idx(grant_idx), .frame_cnt(frame_cnt), .abort_cnt(abort_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk_mac = ~clk_mac;

    function automatic logic [7:0] pat(input int s, input int p);
        return 8'(64 * s + p + 3);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_vld = '0; req_sof = '0; req_eof = '0; req_err = '0; req_dat = '0;
        tx_ack = 1'b1;
        for (int s = 0; s < N; s++) begin
            s_len[s] = 0; s_nfr[s] = 0; s_drop[s] = -1; s_err[s] = -1;
            s_pos[s] = 0; s_start[s] = 0; nbeats[s] = 0;
        end
        gseq.delete();
        order_err = 0; b2b = 0; txv_cnt = 0; gv_after_err = -1; first_tx_cyc = -1;
        repeat (2) @(posedge clk_mac);
        #1 rst = 1'b0;
    endtask

    task automatic drive_srcs(input int cyc);
        for (int s = 0; s < N; s++) begin
            logic v, so, eo, er;
            logic [7:0] d;
            v = 1'b0; so = 1'b0; eo = 1'b0; er = 1'b0; d = 8'h00;
            if (s_nfr[s] > 0 && cyc >= s_start[s] && s_pos[s] != s_drop[s]) begin
                v  = 1'b1;
                so = (s_pos[s] == 0);
                d  = pat(s, s_pos[s]);
                if (s_pos[s] == s_err[s]) begin
                    er = 1'b1;
                end else if (s_pos[s] >= s_len[s]) begin
                    eo = 1'b1;
                    d  = 8'h00;
                end
            end
            req_vld[s] = v; req_sof[s] = so; req_eof[s] = eo; req_err[s] = er;
            req_dat[8*s +: 8] = d;
        end
    endtask

    // Runs ncyc cycles: drive after the edge, observe 1 time unit later, advance after the next edge.
    task automatic run(input int ncyc);
        logic [N-1:0] acc;
        logic         prev_gv;
        logic [2:0]   prev_gi;
        logic         err_pending;
        int           inframe;
        prev_gv = grant_vld; prev_gi = grant_idx; err_pending = 1'b0; inframe = 0;
        for (int c = 0; c < ncyc; c++) begin
            drive_srcs(c);
            #1;
            if (err_pending) begin
                gv_after_err = int'(grant_vld);
                err_pending  = 1'b0;
            end
            if (grant_vld && !prev_gv) begin
                gseq.push_back(int'(grant_idx));
                inframe = 0;
            end
            if (grant_vld && prev_gv && grant_idx != prev_gi) b2b++;
            if (tx_vld) begin
                txv_cnt++;
                if (first_tx_cyc < 0) first_tx_cyc = c;
            end
            if (tx_vld && tx_ack && !tx_eof && !tx_err) begin
                if (tx_dat !== pat(int'(grant_idx), inframe) || tx_sof !== (inframe == 0)) order_err++;
                inframe++;
                nbeats[grant_idx]++;
            end
            if (tx_vld && tx_ack && tx_err) err_pending = 1'b1;
            acc     = req_vld & req_ack;
            prev_gv = grant_vld;
            prev_gi = grant_idx;
            @(posedge clk_mac);
            #1;
            for (int s = 0; s < N; s++) begin
                if (acc[s]) begin
                    if (req_eof[s] || req_err[s]) begin
                        s_nfr[s]--;
                        s_pos[s] = 0;
                    end else begin
                        s_pos[s]++;
                    end
                end
            end
        end
    endtask

    function automatic int seq_code();
        int code;
        code = 0;
        foreach (gseq[i]) code = code * 10 + gseq[i] + 1;
        return code;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req_en = 2'b11; req_vld = 2'b11; req_sof = 2'b00; tx_ack = 1'b1;
        #1;
        total++; if (req_ack !== 2'b00) $display("FAIL reset_ack: got %b want 00", req_ack); else passed++;
        total++; if (tx_vld !== 1'b0) $display("FAIL reset_tx_vld: got %b want 0", tx_vld); else passed++;
        do_reset();
        #1;
        total++; if (grant_vld !== 1'b0 || grant_idx !== 3'd0) $display("FAIL reset_grant: got %b/%0d want 0/0", grant_vld, grant_idx); else passed++;
        total++; if ({frame_cnt, abort_cnt, drop_cnt} !== 12'h000) $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", frame_cnt, abort_cnt, drop_cnt); else passed++;
    endtask

    task automatic test_single();
        do_reset(); req_en = 2'b11;
        s_len[0] = 61; s_nfr[0] = 1;
        run(70);
        total++; if (nbeats[0] != 61) $display("FAIL single_beats: got %0d want 61", nbeats[0]); else passed++;
        total++; if (order_err != 0) $display("FAIL single_order: got %0d errors want 0", order_err); else passed++;
        total++; if (frame_cnt !== 4'd1 || abort_cnt !== 4'd0) $display("FAIL single_counts: got %0d/%0d want 1/0", frame_cnt, abort_cnt); else passed++;
        total++; if (grant_idx !== 3'd0) $display("FAIL single_grant_idx: got %0d want 0", grant_idx); else passed++;
        total++; if (first_tx_cyc != 1) $display("FAIL single_latency: got cycle %0d want 1", first_tx_cyc); else passed++;
        total++; if (grant_vld !== 1'b0 || seq_code() != 1) $display("FAIL single_release: got gv %b seq %0d want 0/1", grant_vld, seq_code()); else passed++;
    endtask

    task automatic test_contention();
        do_reset(); req_en = 2'b11;
        s_len[0] = 3; s_nfr[0] = 2;
        s_len[1] = 3; s_nfr[1] = 2;
        run(40);
        total++; if (seq_code() != 1212) $display("FAIL contention_order: got %0d want 1212", seq_code()); else passed++;
        total++; if (b2b != 0) $display("FAIL contention_idle_gap: got %0d direct handovers want 0", b2b); else passed++;
        total++; if (frame_cnt !== 4'd4) $display("FAIL contention_frames: got %0d want 4", frame_cnt); else passed++;
        total++; if (nbeats[0] != 6 || nbeats[1] != 6 || order_err != 0) $display("FAIL contention_beats: got %0d/%0d err %0d want 6/6/0", nbeats[0], nbeats[1], order_err); else passed++;
    endtask

    task automatic test_abort();
        do_reset(); req_en = 2'b11;
        s_len[1] = 20; s_nfr[1] = 1; s_drop[1] = 9;
        s_len[0] = 4;  s_nfr[0] = 1; s_start[0] = 3;
        run(40);
        total++; if (abort_cnt !== 4'd1 || frame_cnt !== 4'd1) $display("FAIL abort_counts: got %0d/%0d want 1/1", abort_cnt, frame_cnt); else passed++;
        total++; if (seq_code() != 21) $display("FAIL abort_next_grant: got %0d want 21", seq_code()); else passed++;
        total++; if (nbeats[1] != 9 || nbeats[0] != 4) $display("FAIL abort_beats: got %0d/%0d want 9/4", nbeats[1], nbeats[0]); else passed++;
    endtask

    task automatic test_error();
        do_reset(); req_en = 2'b11;
        s_len[0] = 20; s_nfr[0] = 1; s_err[0] = 4;
        run(20);
        total++; if (abort_cnt !== 4'd1 || frame_cnt !== 4'd0) $display("FAIL error_counts: got %0d/%0d want 1/0", abort_cnt, frame_cnt); else passed++;
        total++; if (gv_after_err != 0) $display("FAIL error_release: got grant_vld %0d want 0", gv_after_err); else passed++;
        total++; if (nbeats[0] != 4) $display("FAIL error_beats: got %0d want 4", nbeats[0]); else passed++;
    endtask

    task automatic test_stray();
        do_reset(); req_en = 2'b11;
        for (int i = 0; i < 3; i++) begin
            req_vld = 2'b10; req_sof = 2'b00;
            #1;
            total++; if (req_ack !== 2'b10 || tx_vld !== 1'b0) $display("FAIL stray_ack%0d: got ack %b tx_vld %b want 10/0", i, req_ack, tx_vld); else passed++;
            @(posedge clk_mac); #1;
        end
        req_vld = 2'b00;
        #1;
        total++; if (drop_cnt !== 4'd3) $display("FAIL stray_drop_cnt: got %0d want 3", drop_cnt); else passed++;
        req_en = 2'b01; req_vld = 2'b10;
        #1;
        total++; if (req_ack !== 2'b00) $display("FAIL stray_disabled_ack: got %b want 00", req_ack); else passed++;
        @(posedge clk_mac); #1;
        req_vld = 2'b00;
        total++; if (drop_cnt !== 4'd3) $display("FAIL stray_disabled_cnt: got %0d want 3", drop_cnt); else passed++;
    endtask

    task automatic test_saturate();
        do_reset(); req_en = 2'b11; req_vld = 2'b11; req_sof = 2'b00;
        repeat (7) @(posedge clk_mac);
        #1;
        total++; if (drop_cnt !== 4'd14) $display("FAIL sat_pre: got %0d want 14", drop_cnt); else passed++;
        repeat (3) @(posedge clk_mac);
        #1;
        total++; if (drop_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", drop_cnt); else passed++;
        req_vld = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset(); req_en = 2'b11;
        s_len[0] = 3; s_nfr[0] = 2;
        run(8);
        total++; if (frame_cnt !== 4'd1 || grant_vld !== 1'b1) $display("FAIL rstmid_pre: got %0d/%b want 1/1", frame_cnt, grant_vld); else passed++;
        drive_srcs(8);
        rst = 1'b1;
        #1;
        total++; if (tx_vld !== 1'b0 || req_ack !== 2'b00) $display("FAIL rstmid_outputs: got tx_vld %b ack %b want 0/00", tx_vld, req_ack); else passed++;
        total++; if (frame_cnt !== 4'd0 || grant_vld !== 1'b0) $display("FAIL rstmid_state: got %0d/%b want 0/0", frame_cnt, grant_vld); else passed++;
        @(posedge clk_mac); #1 rst = 1'b0;
    endtask

    task automatic test_mask();
        do_reset(); req_en = 2'b10;
        s_len[0] = 3; s_nfr[0] = 1;
        s_len[1] = 3; s_nfr[1] = 2;
        run(30);
        total++; if (nbeats[0] != 0 || seq_code() != 22) $display("FAIL mask_grants: got beats0 %0d seq %0d want 0/22", nbeats[0], seq_code()); else passed++;
        total++; if (frame_cnt !== 4'd2 || drop_cnt !== 4'd0) $display("FAIL mask_counts: got %0d/%0d want 2/0", frame_cnt, drop_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_error();
        test_stray();
        test_saturate();
        test_reset_mid();
        test_mask();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
